pipe_hazard_ctrl: RTL and testbench

- Produces the enable/flush controls consumed by the IF/ID, ID/RR, RR/EX and EX/MEM pipeline registers of the 6-stage core.
- Generates operand-forwarding selects for the EX stage.
- Sequences branch-mispredict recovery through a small FSM.
- Keeps saturating stall and flush event counters for debug.

---
 rtl/pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for the 6-stage core: pipeline register enables/flushes,
// EX operand forwarding selects, mispredict redirect sequencing and
// saturating debug counters for stall and flush events.

// Forwarding select for one EX operand.
// Priority is youngest producer first: EX, then MEM, then WB, else RF.
// A load in EX has no data yet, so it is never an EX forward source.
module pipe_hazard_fwd_sel #(
   parameter int REG_AW = 3
) (
   input  logic              use_src,
   input  logic [REG_AW-1:0] src_a,
   input  logic              ex_valid,
   input  logic              ex_wr_en,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_a3,
   input  logic              mem_wr_en,
   input  logic [REG_AW-1:0] mem_a3,
   input  logic              wb_wr_en,
   input  logic [REG_AW-1:0] wb_a3,
   output logic [1:0]        sel
);

   // Select the youngest matching producer; unused operands always read RF
   always_comb begin
      sel = 2'b00;
      if (use_src) begin
         if (ex_valid && ex_wr_en && !ex_is_load && (ex_a3 == src_a))
            sel = 2'b01;
         else if (mem_wr_en && (mem_a3 == src_a))
            sel = 2'b10;
         else if (wb_wr_en && (wb_a3 == src_a))
            sel = 2'b11;
      end
   end

endmodule

module pipe_hazard_ctrl #(
   parameter int REG_AW = 3,
   parameter int PC_W   = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rr_valid,
   input  logic [REG_AW-1:0] rr_a1,
   input  logic [REG_AW-1:0] rr_a2,
   input  logic              rr_use_a1,
   input  logic              rr_use_a2,
   input  logic              ex_valid,
   input  logic              ex_wr_en,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_a3,
   input  logic              mem_wr_en,
   input  logic [REG_AW-1:0] mem_a3,
   input  logic              wb_wr_en,
   input  logic [REG_AW-1:0] wb_a3,
   input  logic              ex_mispredict,
   input  logic [PC_W-1:0]   ex_target,
   input  logic              ext_stall,
   output logic              if_id_en,
   output logic              id_rr_en,
   output logic              rr_ex_en,
   output logic              ex_mem_en,
   output logic              if_id_flush,
   output logic              id_rr_flush,
   output logic              rr_ex_flush,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              pc_redirect_valid,
   output logic [PC_W-1:0]   pc_redirect,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic {
      RUN   = 1'b0,
      REDIR = 1'b1
   } state_e;

   localparam int NUM_SRC = 2;

   state_e                   state_q, state_d;
   logic                     redir_vld_q, redir_vld_d;
   logic [PC_W-1:0]          redir_pc_q, redir_pc_d;
   logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]         flush_cnt_q, flush_cnt_d;
   logic                     stall_ev;
   logic                     flush_ev;
   logic                     load_use;

   logic [NUM_SRC-1:0][REG_AW-1:0] src_a;
   logic [NUM_SRC-1:0]             src_use;
   logic [NUM_SRC-1:0][1:0]        src_sel;

   assign src_a   = {rr_a2, rr_a1};
   assign src_use = {rr_use_a2, rr_use_a1};

   // One forwarding selector per EX operand
   for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
      pipe_hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd (
         .use_src   (src_use[s]),
         .src_a     (src_a[s]),
         .ex_valid  (ex_valid),
         .ex_wr_en  (ex_wr_en),
         .ex_is_load(ex_is_load),
         .ex_a3     (ex_a3),
         .mem_wr_en (mem_wr_en),
         .mem_a3    (mem_a3),
         .wb_wr_en  (wb_wr_en),
         .wb_a3     (wb_a3),
         .sel       (src_sel[s])
      );
   end

   assign fwd_a_sel = src_sel[0];
   assign fwd_b_sel = src_sel[1];

   // RR reads a register the EX load has not produced yet
   always_comb begin
      load_use = rr_valid && ex_valid && ex_is_load && ex_wr_en &&
                 ((rr_use_a1 && (rr_a1 == ex_a3)) ||
                  (rr_use_a2 && (rr_a2 == ex_a3)));
   end

   // Control FSM: register enables/flushes, redirect pulse, event strobes
   always_comb begin
      state_d     = state_q;
      redir_vld_d = redir_vld_q;
      redir_pc_d  = redir_pc_q;
      stall_ev    = 1'b0;
      flush_ev    = 1'b0;
      if_id_en    = 1'b1;
      id_rr_en    = 1'b1;
      rr_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      if_id_flush = 1'b0;
      id_rr_flush = 1'b0;
      rr_ex_flush = 1'b0;

      unique case (state_q)
         RUN: begin
            redir_vld_d = 1'b0;
            if (ext_stall) begin
               // Freeze everything; the held EX instruction re-raises any
               // mispredict or load-use once memory is free.
               if_id_en  = 1'b0;
               id_rr_en  = 1'b0;
               rr_ex_en  = 1'b0;
               ex_mem_en = 1'b0;
               stall_ev  = 1'b1;
            end else if (ex_mispredict && ex_valid) begin
               // Squash the three younger wrong-path instructions
               if_id_flush = 1'b1;
               id_rr_flush = 1'b1;
               rr_ex_flush = 1'b1;
               redir_pc_d  = ex_target;
               redir_vld_d = 1'b1;
               state_d     = REDIR;
               flush_ev    = 1'b1;
            end else if (load_use) begin
               // Hold IF/ID and ID/RR, slip one bubble into EX
               if_id_en    = 1'b0;
               id_rr_en    = 1'b0;
               rr_ex_flush = 1'b1;
               stall_ev    = 1'b1;
            end
         end
         REDIR: begin
            if (ext_stall) begin
               if_id_en  = 1'b0;
               id_rr_en  = 1'b0;
               rr_ex_en  = 1'b0;
               ex_mem_en = 1'b0;
               stall_ev  = 1'b1;
            end else begin
               // Fetch issued before the redirect landed is wrong-path
               if_id_flush = 1'b1;
               redir_vld_d = 1'b0;
               state_d     = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Saturating event counters, at most +1 per cycle
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_ev && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_ev && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // State, redirect and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= RUN;
         redir_vld_q <= 1'b0;
         redir_pc_q  <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         redir_vld_q <= redir_vld_d;
         redir_pc_q  <= redir_pc_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign pc_redirect_valid = redir_vld_q;
   assign pc_redirect       = redir_pc_q;
   assign stall_cnt         = stall_cnt_q;
   assign flush_cnt         = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl built with CNT_W=4 so the
// counter saturation case is reachable in a few cycles.
module tb_pipe_hazard_ctrl;

   localparam int REG_AW = 3;
   localparam int PC_W   = 16;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              rr_valid, rr_use_a1, rr_use_a2;
   logic [REG_AW-1:0] rr_a1, rr_a2;
   logic              ex_valid, ex_wr_en, ex_is_load;
   logic [REG_AW-1:0] ex_a3;
   logic              mem_wr_en, wb_wr_en;
   logic [REG_AW-1:0] mem_a3, wb_a3;
   logic              ex_mispredict;
   logic [PC_W-1:0]   ex_target;
   logic              ext_stall;
   logic              if_id_en, id_rr_en, rr_ex_en, ex_mem_en;
   logic              if_id_flush, id_rr_flush, rr_ex_flush;
   logic [1:0]        fwd_a_sel, fwd_b_sel;
   logic              pc_redirect_valid;
   logic [PC_W-1:0]   pc_redirect;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   int n_vec = 0;
   int n_err = 0;

   pipe_hazard_ctrl #(.REG_AW(REG_AW), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .rr_valid(rr_valid), .rr_a1(rr_a1), .rr_a2(rr_a2),
      .rr_use_a1(rr_use_a1), .rr_use_a2(rr_use_a2),
      .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
      .ex_a3(ex_a3), .mem_wr_en(mem_wr_en), .mem_a3(mem_a3),
      .wb_wr_en(wb_wr_en), .wb_a3(wb_a3),
      .ex_mispredict(ex_mispredict), .ex_target(ex_target),
      .ext_stall(ext_stall),
      .if_id_en(if_id_en), .id_rr_en(id_rr_en), .rr_ex_en(rr_ex_en),
      .ex_mem_en(ex_mem_en),
      .if_id_flush(if_id_flush), .id_rr_flush(id_rr_flush),
      .rr_ex_flush(rr_ex_flush),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .pc_redirect_valid(pc_redirect_valid), .pc_redirect(pc_redirect),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; inputs change 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rr_valid = 0; rr_use_a1 = 0; rr_use_a2 = 0; rr_a1 = 0; rr_a2 = 0;
      ex_valid = 0; ex_wr_en = 0; ex_is_load = 0; ex_a3 = 0;
      mem_wr_en = 0; mem_a3 = 0; wb_wr_en = 0; wb_a3 = 0;
      ex_mispredict = 0; ex_target = 0; ext_stall = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 0;
      tick();
      rst = 1;
      #1;
   endtask

   function automatic int ens();
      return {if_id_en, id_rr_en, rr_ex_en, ex_mem_en};
   endfunction

   function automatic int fls();
      return {if_id_flush, id_rr_flush, rr_ex_flush};
   endfunction

   initial begin
      // Reset with random inputs for two edges
      idle();
      rst = 0;
      for (int i = 0; i < 2; i++) begin
         rr_valid = 1'($urandom); rr_use_a1 = 1'($urandom);
         rr_use_a2 = 1'($urandom); rr_a1 = 3'($urandom); rr_a2 = 3'($urandom);
         ex_valid = 1'($urandom); ex_wr_en = 1'($urandom);
         ex_is_load = 1'($urandom); ex_a3 = 3'($urandom);
         mem_wr_en = 1'($urandom); mem_a3 = 3'($urandom);
         wb_wr_en = 1'($urandom); wb_a3 = 3'($urandom);
         ex_mispredict = 1'($urandom); ex_target = 16'($urandom);
         ext_stall = 1'($urandom);
         tick();
      end
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      chk("rst_redir_vld", pc_redirect_valid, 0);
      chk("rst_redir_pc", pc_redirect, 0);
      idle();
      rst = 1;
      #1;
      chk("rst_enables", ens(), 4'hF);
      chk("rst_flushes", fls(), 3'b000);

      // Load-use: EX load r3, RR reads r3 on operand a
      ex_valid = 1; ex_is_load = 1; ex_wr_en = 1; ex_a3 = 3;
      rr_valid = 1; rr_use_a1 = 1; rr_a1 = 3;
      #1;
      chk("lu_enables", ens(), 4'b0011);
      chk("lu_flushes", fls(), 3'b001);
      chk("lu_fwd_a_no_ex", fwd_a_sel, 2'b00);
      tick();
      chk("lu_stall_cnt", stall_cnt, 1);
      ex_valid = 0; ex_is_load = 0; ex_wr_en = 0;
      mem_wr_en = 1; mem_a3 = 3;
      #1;
      chk("lu_fwd_a_mem", fwd_a_sel, 2'b10);
      chk("lu_enables_after", ens(), 4'hF);
      tick();
      chk("lu_single_bubble", stall_cnt, 1);

      // Forward priority on operand b
      idle();
      rr_a2 = 5; rr_use_a2 = 1;
      ex_valid = 1; ex_wr_en = 1; ex_a3 = 5;
      mem_wr_en = 1; mem_a3 = 5; wb_wr_en = 1; wb_a3 = 5;
      #1;
      chk("fwd_b_ex", fwd_b_sel, 2'b01);
      chk("fwd_a_unused", fwd_a_sel, 2'b00);
      ex_wr_en = 0; #1;
      chk("fwd_b_mem", fwd_b_sel, 2'b10);
      mem_wr_en = 0; #1;
      chk("fwd_b_wb", fwd_b_sel, 2'b11);
      rr_use_a2 = 0; #1;
      chk("fwd_b_unused", fwd_b_sel, 2'b00);
      rr_use_a2 = 1; wb_a3 = 4; #1;
      chk("fwd_b_nomatch", fwd_b_sel, 2'b00);
      rr_use_a1 = 1; rr_a1 = 5; ex_wr_en = 1; #1;
      chk("fwd_a_ex", fwd_a_sel, 2'b01);

      // Mispredict; mispredict held high during REDIR must be ignored
      do_reset();
      ex_valid = 1; ex_mispredict = 1; ex_target = 16'h0040;
      #1;
      chk("mp_flushes", fls(), 3'b111);
      chk("mp_enables", ens(), 4'hF);
      tick();
      ex_target = 16'h1234;
      #1;
      chk("mp_redir_vld", pc_redirect_valid, 1);
      chk("mp_redir_pc", pc_redirect, 16'h0040);
      chk("mp_redir_flushes", fls(), 3'b100);
      chk("mp_redir_enables", ens(), 4'hF);
      chk("mp_flush_cnt", flush_cnt, 1);
      tick();
      idle();
      #1;
      chk("mp_vld_drop", pc_redirect_valid, 0);
      chk("mp_pc_hold", pc_redirect, 16'h0040);
      chk("mp_run_flushes", fls(), 3'b000);
      chk("mp_flush_cnt2", flush_cnt, 1);

      // Stall dominates mispredict for 3 cycles, then redirect proceeds
      do_reset();
      ext_stall = 1; ex_valid = 1; ex_mispredict = 1; ex_target = 16'h0080;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("sim_enables", ens(), 4'h0);
         chk("sim_flushes", fls(), 3'b000);
         tick();
      end
      chk("sim_stall_cnt", stall_cnt, 3);
      chk("sim_no_redir", pc_redirect_valid, 0);
      chk("sim_flush_cnt0", flush_cnt, 0);
      ext_stall = 0;
      #1;
      chk("sim_mp_flushes", fls(), 3'b111);
      tick();
      // Freeze inside REDIR
      ex_mispredict = 0; ext_stall = 1;
      #1;
      chk("sim_redir_vld", pc_redirect_valid, 1);
      chk("sim_redir_pc", pc_redirect, 16'h0080);
      chk("redir_stall_en", ens(), 4'h0);
      chk("redir_stall_fl", fls(), 3'b000);
      tick();
      chk("redir_stall_vld", pc_redirect_valid, 1);
      chk("redir_stall_cnt", stall_cnt, 4);
      ext_stall = 0;
      #1;
      chk("redir_resume_fl", fls(), 3'b100);
      tick();
      chk("redir_done_vld", pc_redirect_valid, 0);
      chk("sim_flush_cnt1", flush_cnt, 1);

      // Reset in REDIR abandons the redirect
      do_reset();
      ex_valid = 1; ex_mispredict = 1; ex_target = 16'h00AA;
      tick();
      idle();
      rst = 0;
      tick();
      rst = 1;
      #1;
      chk("rst_redir_abandon", pc_redirect_valid, 0);
      chk("rst_redir_state", fls(), 3'b000);

      // Counter saturation
      do_reset();
      ext_stall = 1;
      for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
      chk("sat_stall_cnt", stall_cnt, 4'hF);
      chk("sat_flush_cnt", flush_cnt, 0);
      ext_stall = 0;
      tick();
      chk("sat_hold", stall_cnt, 4'hF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
